dmem_arbiter: RTL and testbench

Shares the single-port 64-bit data memory between two requesters: the pipeline MEM stage (port P) and the debug/loader port (port D).
- The loader port initialises and inspects memory in hardware, replacing testbench-side memory preloads.
- Runs one doubleword transaction at a time through a small FSM with a latency counter.
- Round-robin on simultaneous requests.
- Raises a stall to the pipeline while its access is pending.

---
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port 64-bit data memory between the pipeline (P) and debug/loader (D) ports
//
// One doubleword transaction runs at a time. Simultaneous requests are served
// round-robin. A request sampled in IDLE at edge t drives mem_en in cycle t+1
// and completes (done pulse) in cycle t+1+MEM_LAT.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   p_req/p_we/p_addr/p_wdata    pipeline request (level, held until p_done)
//   p_rdata/p_done/p_stall       pipeline read data, completion pulse, hold request
//   d_req/d_we/d_addr/d_wdata    debug/loader request (level, held until d_done)
//   d_rdata/d_done               debug read data, completion pulse
//   mem_en/mem_we/mem_addr       memory strobe, write strobe, doubleword-aligned address
//   mem_wdata/mem_rdata          memory write/read data
//   misalign                     sticky: some granted request had addr[2:0] != 0
//
// Optional build macro DMEM_ARB_STATS_EN adds the saturating 16-bit counters
// conflict_cnt (IDLE cycles with both requests) and p_wait_cnt (p_stall cycles).
module dmem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       p_wait_cnt,
`endif
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_done,
    output logic              p_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              misalign
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t              state, nstate;
    logic [1:0]          cnt;
    logic                g_p;
    logic                last_p;
    logic                we_q;
    logic [ADDR_W-1:3]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   p_rdata_q, d_rdata_q;
    logic                grant, grant_p;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // P wins unless D is also requesting and P was served last.
    always_comb begin
        grant     = (state == IDLE) & (p_req | d_req);
        grant_p   = p_req & (~d_req | ~last_p);
        sel_we    = grant_p ? p_we    : d_we;
        sel_addr  = grant_p ? p_addr  : d_addr;
        sel_wdata = grant_p ? p_wdata : d_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nstate;
    end

    // WAIT is left when the counter reaches 1, giving MEM_LAT-1 WAIT cycles.
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = (p_req | d_req) ? ACCESS : IDLE;
            ACCESS:  nstate = (MEM_LAT == 1) ? DONE : WAIT;
            WAIT:    nstate = (cnt == 2'd1) ? DONE : WAIT;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            g_p       <= 1'b0;
            last_p    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            p_rdata_q <= '0;
            d_rdata_q <= '0;
            misalign  <= 1'b0;
        end else begin
            if (grant) begin
                g_p      <= grant_p;
                last_p   <= grant_p;
                we_q     <= sel_we;
                addr_q   <= sel_addr[ADDR_W-1:3];
                wdata_q  <= sel_wdata;
                misalign <= misalign | (sel_addr[2:0] != 3'b000);
            end
            if (state == ACCESS)
                cnt <= 2'(MEM_LAT - 1);
            else if (state == WAIT)
                cnt <= cnt - 2'd1;
            if (state == DONE && !we_q && g_p)
                p_rdata_q <= mem_rdata;
            if (state == DONE && !we_q && !g_p)
                d_rdata_q <= mem_rdata;
        end
    end

    // Read data is forwarded straight from memory in the DONE cycle so it is
    // already valid while the done pulse is high; the register holds it after.
    always_comb begin
        mem_en    = state == ACCESS;
        mem_we    = mem_en & we_q;
        mem_addr  = {addr_q, 3'b000};
        mem_wdata = wdata_q;
        p_done    = (state == DONE) & g_p;
        d_done    = (state == DONE) & ~g_p;
        p_rdata   = (p_done & ~we_q) ? mem_rdata : p_rdata_q;
        d_rdata   = (d_done & ~we_q) ? mem_rdata : d_rdata_q;
        p_stall   = p_req & ~p_done;
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
            p_wait_cnt   <= '0;
        end else begin
            if (state == IDLE && p_req && d_req && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
            if (p_stall && p_wait_cnt != 16'hFFFF)
                p_wait_cnt <= p_wait_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        preload;
    logic        p_req, p_we, d_req, d_we;
    logic [9:0]  p_addr, d_addr;
    logic [63:0] p_wdata, d_wdata;
    logic [63:0] p_rdata, d_rdata;
    logic        p_done, p_stall, d_done;
    logic        mem_en, mem_we, misalign;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    int          checks = 0;
    int          fails  = 0;

    logic [63:0] mem [128];
    logic [63:0] pipe [L];
    logic [63:0] ref_mem [128];
    logic [63:0] exp_prd, exp_drd;
    logic        exp_mis;
    bit          m_last_p;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(64), .MEM_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_done(p_done), .p_stall(p_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .misalign(misalign)
    );

    function automatic logic [63:0] init_val(input int i);
        if (i == 2)
            return 64'h1122334455667788;
        return {32'h0BAD_0000 + 32'(i), ~(32'h1357_0000 + 32'(i * 7))};
    endfunction

    function automatic logic [9:0] rnd_addr();
        return {7'($urandom_range(0, 15)), 3'b000};
    endfunction

    // Memory device: read data appears exactly L cycles after mem_en; at any
    // other time the read bus carries a poison pattern.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++)
                mem[i] <= init_val(i);
        end else if (mem_en && mem_we) begin
            mem[mem_addr[9:3]] <= mem_wdata;
        end
        pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[9:3]] : 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 1; i < L; i++)
            pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[L-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One arbitration round starting in an IDLE cycle: either or both ports
    // request with their current inputs. The first grantee finishes L+1 edges
    // later, a second one 2L+3 edges later; each drops its request on its done.
    task automatic do_txn(input bit rp, input bit rd);
        bit          both, first_p, en_exp, pd_exp, dd_exp, is_p, w;
        logic        fw, sw;
        logic [9:0]  fa, sa, a;
        logic [63:0] fd, sd, dv;
        int          e1, e2, n, pe;
        both     = rp && rd;
        first_p  = rp && (!rd || !m_last_p);
        m_last_p = both ? !first_p : first_p;
        fw = first_p ? p_we    : d_we;
        fa = first_p ? p_addr  : d_addr;
        fd = first_p ? p_wdata : d_wdata;
        sw = first_p ? d_we    : p_we;
        sa = first_p ? d_addr  : p_addr;
        sd = first_p ? d_wdata : p_wdata;
        e1 = L + 1;
        e2 = both ? 2 * L + 3 : -1;
        n  = both ? 2 * L + 4 : L + 2;
        pe = first_p ? e1 : e2;
        p_req = rp;
        d_req = rd;
        #1 chk("stall_on_req", p_stall, rp);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            en_exp = (k == 1) || (both && k == L + 3);
            if (k == 1)
                exp_mis = exp_mis | (fa[2:0] != 3'b000);
            if (both && k == L + 3)
                exp_mis = exp_mis | (sa[2:0] != 3'b000);
            chk("mem_en", mem_en, en_exp);
            chk("misalign", misalign, exp_mis);
            if (en_exp) begin
                a  = (k == 1) ? fa : sa;
                w  = (k == 1) ? fw : sw;
                dv = (k == 1) ? fd : sd;
                chk("mem_we", mem_we, w);
                chk("mem_addr", mem_addr, {a[9:3], 3'b000});
                if (w)
                    chk("mem_wdata", mem_wdata, dv);
            end
            if (k == 1) begin
                if (first_p) begin
                    p_addr = 10'($urandom); p_we = 1'($urandom); p_wdata = {$urandom, $urandom};
                end else begin
                    d_addr = 10'($urandom); d_we = 1'($urandom); d_wdata = {$urandom, $urandom};
                end
            end
            pd_exp = (first_p && k == e1) || (both && !first_p && k == e2);
            dd_exp = (!first_p && k == e1) || (both && first_p && k == e2);
            chk("p_done", p_done, pd_exp);
            chk("d_done", d_done, dd_exp);
            chk("p_stall", p_stall, rp && k < pe);
            if (k == e1 || k == e2) begin
                is_p = (k == e1) ? first_p : !first_p;
                w    = (k == e1) ? fw : sw;
                a    = (k == e1) ? fa : sa;
                dv   = (k == e1) ? fd : sd;
                if (w) begin
                    ref_mem[a[9:3]] = dv;
                end else if (is_p) begin
                    exp_prd = ref_mem[a[9:3]];
                    chk("p_rdata_done", p_rdata, exp_prd);
                end else begin
                    exp_drd = ref_mem[a[9:3]];
                    chk("d_rdata_done", d_rdata, exp_drd);
                end
                if (is_p) p_req = 1'b0;
                else      d_req = 1'b0;
            end
        end
        chk("p_rdata_hold", p_rdata, exp_prd);
        chk("d_rdata_hold", d_rdata, exp_drd);
    endtask

    initial begin
        int sel;
        for (int i = 0; i < 128; i++)
            ref_mem[i] = init_val(i);
        exp_prd = '0; exp_drd = '0; exp_mis = 1'b0; m_last_p = 1'b0;
        rst = 1'b1; preload = 1'b1;
        p_req = 1'b1; d_req = 1'b1; p_we = 1'b0; d_we = 1'b0;
        p_addr = '0; d_addr = '0; p_wdata = '0; d_wdata = '0;

        // Reset with both requests held: everything quiet.
        repeat (2) begin
            @(negedge clk);
            chk("rst_mem_en", mem_en, 1'b0);
            chk("rst_mem_we", mem_we, 1'b0);
            chk("rst_p_done", p_done, 1'b0);
            chk("rst_d_done", d_done, 1'b0);
            chk("rst_misalign", misalign, 1'b0);
            chk("rst_p_rdata", p_rdata, 64'h0);
            chk("rst_d_rdata", d_rdata, 64'h0);
            chk("rst_mem_addr", mem_addr, 10'h0);
            chk("rst_mem_wdata", mem_wdata, 64'h0);
        end
        rst = 1'b0; preload = 1'b0; p_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("post_rst_mem_en", mem_en, 1'b0);

        // Tie after reset: P write then D read of the same doubleword.
        p_we = 1'b1; p_addr = 10'h008; p_wdata = 64'h00000000DEADBEEF;
        d_we = 1'b0; d_addr = 10'h008;
        do_txn(1'b1, 1'b1);
        chk("tie_d_rdata", d_rdata, 64'h00000000DEADBEEF);

        // Both held for four transactions: P, D, P, D.
        p_we = 1'b0; d_we = 1'b0; p_addr = rnd_addr(); d_addr = rnd_addr();
        p_req = 1'b1; d_req = 1'b1;
        for (int k = 1; k <= 4 * L + 7; k++) begin
            @(negedge clk);
            chk("hold_p_done", p_done, k == L + 1 || k == 3 * L + 5);
            chk("hold_d_done", d_done, k == 2 * L + 3 || k == 4 * L + 7);
            chk("hold_p_stall", p_stall, !(k == L + 1 || k == 3 * L + 5));
            if (p_done) begin
                exp_prd = ref_mem[p_addr[9:3]];
                chk("hold_p_rdata", p_rdata, exp_prd);
                p_addr = rnd_addr();
            end
            if (d_done) begin
                exp_drd = ref_mem[d_addr[9:3]];
                chk("hold_d_rdata", d_rdata, exp_drd);
                d_addr = rnd_addr();
            end
        end
        p_req = 1'b0; d_req = 1'b0; m_last_p = 1'b0;
        @(negedge clk);

        // P read alone from the preloaded location.
        p_we = 1'b0; p_addr = 10'h010;
        do_txn(1'b1, 1'b0);
        chk("p_read_010", p_rdata, 64'h1122334455667788);

        // Reset during WAIT of a D read.
        d_we = 1'b0; d_addr = 10'h018; d_req = 1'b1;
        @(negedge clk);
        chk("rstw_access_en", mem_en, 1'b1);
        @(negedge clk);
        chk("rstw_wait_en", mem_en, 1'b0);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk("rstw_d_done", d_done, 1'b0);
        chk("rstw_mem_en", mem_en, 1'b0);
        chk("rstw_p_rdata", p_rdata, 64'h0);
        chk("rstw_d_rdata", d_rdata, 64'h0);
        rst = 1'b0;
        exp_prd = '0; exp_drd = '0; exp_mis = 1'b0; m_last_p = 1'b0;
        p_we = 1'b0; p_addr = 10'h000;
        do_txn(1'b1, 1'b0);
        chk("after_rst_p_read", p_rdata, init_val(0));

        // Misaligned D read: aligned access, sticky flag.
        d_we = 1'b0; d_addr = 10'h013;
        do_txn(1'b0, 1'b1);
        chk("misalign_set", misalign, 1'b1);
        chk("misalign_data", d_rdata, init_val(2));

        // Random mix of single and simultaneous transactions.
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(1, 3);
            p_we = 1'($urandom); p_addr = rnd_addr(); p_wdata = {$urandom, $urandom};
            d_we = 1'($urandom); d_addr = rnd_addr(); d_wdata = {$urandom, $urandom};
            do_txn(sel[0], sel[1]);
        end
        chk("misalign_sticky", misalign, 1'b1);

        // Read back every touched doubleword through D.
        for (int i = 0; i < 16; i++) begin
            d_we = 1'b0; d_addr = {7'(i), 3'b000};
            do_txn(1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
